// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the 1:4 round-robin dispatcher.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    // IDLE: output register empty. HOLD: one word is waiting on channel out_sel.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // One-hot decode of a channel select.
    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux4_dispatcher_rr_pick4.sv
// Round-robin picker: first set bit of mask scanning ptr, ptr+1, ... with wrap 3->0.
module rr_pick4
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]  ptr,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  sel,
    output logic              any
);

    logic [NUM_CH-1:0] rot;

    // Rotate the mask so bit 0 is the channel at ptr.
    always_comb begin
        rot = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            rot[i] = mask[SEL_W'(ptr + SEL_W'(i))];
        end
    end

    // Scan from the far end so the nearest set bit wins; sel is don't-care when mask is zero.
    always_comb begin
        sel = ptr;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sel = SEL_W'(ptr + SEL_W'(i));
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/demux4_dispatcher.sv
// Round-robin 1:4 dispatcher: one-word output register, select/valid for a 1:4 demux.
module demux4_dispatcher
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              busy
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q,   ptr_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [DATA_W-1:0]  data_q,  data_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               run_q,   run_d;

    logic [SEL_W-1:0]   pick_ptr;
    logic [SEL_W-1:0]   pick_sel;
    logic               pick_any;
    logic               out_fire;
    logic               in_fire;

    // Back-to-back reloads continue from the channel after the one just served.
    assign pick_ptr = (state_q == HOLD) ? SEL_W'(sel_q + SEL_W'(1)) : ptr_q;

    rr_pick4 u_pick (
        .ptr  (pick_ptr),
        .mask (ch_en),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    // Handshake decode; run_q keeps in_ready low while reset is asserted.
    always_comb begin
        in_ready = 1'b0;
        out_fire = 1'b0;
        if (state_q == HOLD) begin
            out_fire = out_ready[sel_q];
            in_ready = run_q & out_ready[sel_q] & pick_any;
        end else begin
            in_ready = run_q & pick_any;
        end
        in_fire = in_valid & in_ready;
    end

    // Next-state, pointer, held word and counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        run_d   = 1'b1;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    data_d  = in_data;
                    sel_d   = pick_sel;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_fire) begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    ptr_d = SEL_W'(sel_q + SEL_W'(1));
                    if (in_fire) begin
                        data_d  = in_data;
                        sel_d   = pick_sel;
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        out_valid = '0;
        if (state_q == HOLD) begin
            out_valid = sel_onehot(sel_q);
        end
    end

    assign out_data = data_q;
    assign out_sel  = sel_q;
    assign word_cnt = cnt_q;
    assign busy     = (state_q == HOLD);

endmodule

// File: tb/tb_demux4_dispatcher.sv
// Directed bench for demux4_dispatcher; a second instance with CNT_W=4 checks counter wrap.
module tb_demux4_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [3:0]  ch_en;
    logic [3:0]  out_ready;

    logic        in_ready,  in_ready4;
    logic [3:0]  out_valid, out_valid4;
    logic [7:0]  out_data,  out_data4;
    logic [1:0]  out_sel,   out_sel4;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt4;
    logic        busy,      busy4;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    demux4_dispatcher #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ch_en(ch_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel), .word_cnt(word_cnt), .busy(busy)
    );

    demux4_dispatcher #(.DATA_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .ch_en(ch_en), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .out_sel(out_sel4), .word_cnt(word_cnt4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_sel [4];
        exp_sel[0] = 2'd1; exp_sel[1] = 2'd3; exp_sel[2] = 2'd1; exp_sel[3] = 2'd3;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        ch_en     = 4'b1111;
        out_ready = 4'b1111;
        #3;
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_word_cnt",  32'(word_cnt),  32'h0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("idle_in_ready", 32'(in_ready), 32'h1);

        // Round-robin over all channels, back-to-back.
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'hA0 + 8'(i);
            step();
            chk("rr_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
            chk("rr_data",  32'(out_data),  32'(8'hA0 + 8'(i)));
            chk("rr_cnt",   32'(word_cnt),  32'(i));
        end
        in_valid = 1'b0;
        step();
        chk("rr_cnt_end",   32'(word_cnt),  32'd8);
        chk("rr_idle_valid",32'(out_valid), 32'h0);

        // Disabled channels are skipped.
        ch_en    = 4'b1010;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hB0 + 8'(i);
            step();
            chk("skip_sel",  32'(out_sel),  32'(exp_sel[i]));
            chk("skip_data", 32'(out_data), 32'(8'hB0 + 8'(i)));
        end
        in_valid = 1'b0;
        step();
        chk("skip_cnt", 32'(word_cnt), 32'd12);

        // Backpressure on channel 2; others ready but ignored.
        ch_en     = 4'b0100;
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_data   = 8'hC0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",    32'(out_valid), 32'b0100);
            chk("bp_data",     32'(out_data),  32'hC0);
            chk("bp_in_ready", 32'(in_ready),  32'h0);
            step();
        end
        out_ready = 4'b1111;
        step();
        chk("bp_fire_cnt", 32'(word_cnt),  32'd13);
        chk("bp_idle",     32'(out_valid), 32'h0);
        ch_en    = 4'b1111;
        in_valid = 1'b1;
        in_data  = 8'hD0;
        step();
        chk("bp_next_sel", 32'(out_sel), 32'd3);
        in_valid = 1'b0;
        step();
        chk("bp_next_cnt", 32'(word_cnt), 32'd14);

        // Enable dropped while the word is held for channel 1.
        ch_en     = 4'b0010;
        out_ready = 4'b1101;
        in_valid  = 1'b1;
        in_data   = 8'hE0;
        step();
        in_valid = 1'b0;
        ch_en    = 4'b1101;
        step();
        chk("en_hold_valid", 32'(out_valid), 32'b0010);
        chk("en_hold_data",  32'(out_data),  32'hE0);
        chk("en_hold_ready", 32'(in_ready),  32'h0);
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 8'hE1;
        #1;
        chk("en_b2b_ready",  32'(in_ready),  32'h1);
        step();
        chk("en_next_valid", 32'(out_valid), 32'b0100);
        chk("en_next_data",  32'(out_data),  32'hE1);
        chk("en_cnt",        32'(word_cnt),  32'd15);
        in_valid = 1'b0;
        ch_en    = 4'b0000;
        #1;
        chk("en_zero_hold_ready", 32'(in_ready), 32'h0);
        step();
        chk("en_zero_idle_ready", 32'(in_ready),  32'h0);
        chk("en_zero_idle_valid", 32'(out_valid), 32'h0);
        chk("en_zero_cnt",        32'(word_cnt),  32'd16);

        // Reset while a word is held.
        ch_en     = 4'b1111;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 8'hF0;
        step();
        in_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_ready", 32'(in_ready),  32'h0);
        chk("mid_rst_cnt",   32'(word_cnt),  32'h0);
        chk("mid_rst_sel",   32'(out_sel),   32'h0);
        chk("mid_rst_data",  32'(out_data),  32'h0);
        chk("mid_rst_busy",  32'(busy),      32'h0);
        step();
        rst_n     = 1'b1;
        out_ready = 4'b1111;
        step();
        step();

        // 17 words: 16-bit counter reads 17, 4-bit counter wraps to 1.
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'(i);
            step();
            chk("wrap_sel", 32'(out_sel), 32'(i % 4));
        end
        in_valid = 1'b0;
        step();
        chk("wrap_cnt16", 32'(word_cnt),  32'd17);
        chk("wrap_cnt4",  32'(word_cnt4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
